// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the iterative decryption core.
//   - BLK_W / KEY_W / NR / RK_W width and round-count constants
//   - FSM state codes IDLE, ROUND, DONE
//   - inverse S-box table with an inv_sbox() lookup helper
//   - xtime() and gf_mul() GF(2^8) helpers used by InvMixColumns
package aes_pkg;

    localparam int BLK_W = 128;
    localparam int KEY_W = 256;
    localparam int NR    = 14;
    localparam int RK_W  = BLK_W * (NR + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Entry 0x00 sits in the top byte, so entry b is bits [2047-8b -: 8].
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply b by a small constant c (9, 11, 13, 14 in practice) as a
    // sum of xtime powers selected by the bits of c.
    function automatic logic [7:0] gf_mul(input logic [3:0] c, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] pw;
        acc = '0;
        pw  = b;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) begin
                acc = acc ^ pw;
            end
            pw = xtime(pw);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round.
//   st    in   128  current state, byte 0 = st[127:120], column-major
//   rkey  in   128  round key added after InvSubBytes
//   last  in   1    1 = final round, InvMixColumns skipped
//   nxt   out  128  next state
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] st,
    input  logic [BLK_W-1:0] rkey,
    input  logic             last,
    output logic [BLK_W-1:0] nxt
);

    // Byte k lives at row k%4, column k/4. InvShiftRows rotates row r right
    // by r, so the byte landing in column c comes from column (c-r) mod 4.
    always_comb begin
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        nxt = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[4*c + r] = inv_sbox(st[127 - 8*(4*((c - r + 4) % 4) + r) -: 8])
                             ^ rkey[127 - 8*(4*c + r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c];
            a1 = t[4*c + 1];
            a2 = t[4*c + 2];
            a3 = t[4*c + 3];
            if (last) begin
                nxt[127 - 32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                nxt[127 - 32*c -: 32] = {
                    gf_mul(4'he, a0) ^ gf_mul(4'hb, a1) ^ gf_mul(4'hd, a2) ^ gf_mul(4'h9, a3),
                    gf_mul(4'h9, a0) ^ gf_mul(4'he, a1) ^ gf_mul(4'hb, a2) ^ gf_mul(4'hd, a3),
                    gf_mul(4'hd, a0) ^ gf_mul(4'h9, a1) ^ gf_mul(4'he, a2) ^ gf_mul(4'hb, a3),
                    gf_mul(4'hb, a0) ^ gf_mul(4'hd, a1) ^ gf_mul(4'h9, a2) ^ gf_mul(4'he, a3)
                };
            end
        end
    end

endmodule

// File: rtl/keyexpan.sv
// keyexpan: combinational AES-256 key schedule.
//   key        in   256   cipher key, byte 0 = key[255:248]
//   round_keys out  1920  all 15 round keys, K_r = round_keys[1919-128*r -: 128]
module keyexpan (
    input  logic [255:0]  key,
    output logic [1919:0] round_keys
);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Standard 60-word expansion; every eighth word gets RotWord+SubWord+Rcon,
    // and the word halfway between gets SubWord only (AES-256 specific).
    always_comb begin
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        tmp  = '0;
        for (int i = 0; i < 8; i++) begin
            w[i] = key[255 - 32*i -: 32];
        end
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h000000};
                rcon = {rcon[6:0], 1'b0};
            end else if (i % 8 == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        round_keys = '0;
        for (int i = 0; i < 60; i++) begin
            round_keys[1919 - 32*i -: 32] = w[i];
        end
    end

endmodule

// File: rtl/aes_decr_iter.sv
// aes_decr_iter: iterative AES-256 decryption, one inverse round per clock.
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous reset, active low
//   in_valid   in   1    ciphertext/key offered
//   in_ready   out  1    core idle and able to accept
//   in         in   128  ciphertext block, byte 0 = in[127:120]
//   key        in   256  cipher key
//   out_valid  out  1    plaintext available
//   out_ready  in   1    downstream takes plaintext
//   out        out  128  plaintext block (zero when not valid)
//   busy       out  1    operation in flight (ROUND or DONE)
//   abort      in   1    only when AES_DECR_ABORT_EN is defined
// Configuration macro: AES_DECR_ABORT_EN adds the abort input.
module aes_decr_iter
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in,
    input  logic [KEY_W-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out,
    output logic             busy
`ifdef AES_DECR_ABORT_EN
    ,
    input  logic             abort
`endif
);

    logic [1:0]       state_q, state_d;
    logic [BLK_W-1:0] st_q, st_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             abort_req;
    logic [RK_W-1:0]  round_keys;
    logic [BLK_W-1:0] rkey;
    logic [BLK_W-1:0] round_out;

`ifdef AES_DECR_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    keyexpan u_keyexpan (
        .key        (key_q),
        .round_keys (round_keys)
    );

    // cnt doubles as the round-key index, so select K_cnt directly.
    always_comb begin
        rkey = '0;
        for (int r = 0; r <= NR; r++) begin
            if (cnt_q == 4'(r)) begin
                rkey = round_keys[RK_W - 1 - BLK_W*r -: BLK_W];
            end
        end
    end

    aes_inv_round u_round (
        .st   (st_q),
        .rkey (rkey),
        .last (cnt_q == 4'd0),
        .nxt  (round_out)
    );

    assign in_ready  = rst && (state_q == IDLE) && !abort_req;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ROUND) || (state_q == DONE);
    assign out       = out_valid ? st_q : '0;

    // The first ROUND cycle (cnt=14) is only the initial AddRoundKey;
    // the remaining fourteen use the shared inverse round. Leaving DONE
    // wipes the state so no plaintext lingers after handoff.
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    st_d    = in;
                    key_d   = key;
                    cnt_d   = 4'(NR);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (cnt_q == 4'(NR)) begin
                    st_d = st_q ^ rkey;
                end else begin
                    st_d = round_out;
                end
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    st_d    = '0;
                    key_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                st_d    = '0;
                key_d   = '0;
                cnt_d   = '0;
            end
        endcase
        // Abort wins over everything, including a same-cycle accept.
        if (abort_req) begin
            state_d = IDLE;
            st_d    = '0;
            key_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_aes_decr_iter.sv
// tb_aes_decr_iter: randomized scoreboard bench for aes_decr_iter.
// Expected plaintexts come from known-answer vectors or from a forward
// AES-256 model (S-box derived from GF(2^8) inverses); a cycle-level
// occupancy model predicts in_ready/busy/out_valid timing.
module tb_aes_decr_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_blk = '0;
    logic [255:0] key_in = '0;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_blk;
    logic         busy;
    logic         abort_sig = 1'b0;
    logic         ready_force_en = 1'b1;
    logic         ready_force = 1'b1;
    logic         ready_rand = 1'b1;

    int           checks = 0;
    int           failures = 0;
    int unsigned  cyc = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   sbox_m [256];

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] Z_CT   = 128'hdc95c078a2408989ad48a21492842087;

    assign out_ready = ready_force_en ? ready_force : ready_rand;

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        ready_rand = ($urandom_range(0, 3) != 0);
    end

    aes_decr_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_blk),
        .key       (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_blk),
        .busy      (busy)
`ifdef AES_DECR_ABORT_EN
        ,
        .abort     (abort_sig)
`endif
    );

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        logic [7:0] v;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv;
            v = inv;
            for (int k = 0; k < 4; k++) begin
                v = {v[6:0], v[7]};
                s = s ^ v;
            end
            sbox_m[x] = s ^ 8'h63;
        end
    endtask

    // Forward AES-256 on byte arrays: key schedule, then 14 rounds.
    function automatic logic [127:0] encrypt(input logic [255:0] k, input logic [127:0] p);
        logic [7:0] w [240];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tw [4];
        logic [7:0] tmp, rc, a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 32; i++) w[i] = k[255 - 8*i -: 8];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            for (int j = 0; j < 4; j++) tw[j] = w[4*(i-1) + j];
            if (i % 8 == 0) begin
                tmp = tw[0];
                tw[0] = sbox_m[tw[1]] ^ rc;
                tw[1] = sbox_m[tw[2]];
                tw[2] = sbox_m[tw[3]];
                tw[3] = sbox_m[tmp];
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                for (int j = 0; j < 4; j++) tw[j] = sbox_m[tw[j]];
            end
            for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-8) + j] ^ tw[j];
        end
        for (int i = 0; i < 16; i++) s[i] = p[127 - 8*i -: 8] ^ w[i];
        for (int rnd = 1; rnd <= 14; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) s[4*c + q] = t[4*((c + q) % 4) + q];
            if (rnd < 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd + i];
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = s[i];
        return r;
    endfunction

    // Offer one block, hold it until the core takes it, then record the
    // plaintext the scoreboard should see.
    task automatic applyStimulus(input logic [255:0] k, input logic [127:0] c, input logic [127:0] p);
        int waited;
        bit taken;
        in_valid = 1'b1;
        key_in   = k;
        in_blk   = c;
        waited   = 0;
        taken    = 1'b0;
        while (!taken && waited < 300) begin
            @(negedge clk);
            if (in_ready === 1'b1) taken = 1'b1;
            else waited++;
        end
        if (taken) begin
            exp_q.push_back(p);
        end else begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: actual=no_accept required=accept within 300 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_blk   = {$urandom, $urandom, $urandom, $urandom};
        key_in   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    // Occupancy model: a block is in flight from the accept edge until its
    // handshake; the result shows up 15 edges after acceptance.
    logic        m_busy = 1'b0;
    int unsigned m_acc = 0;
    logic        exp_ov;
    logic        exp_ir;
    logic        prev_hold = 1'b0;
    logic [127:0] prev_out = '0;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            exp_ov = m_busy && (cyc - m_acc >= 15);
            exp_ir = rst && !m_busy && !abort_sig;
            checkOutput("out_valid", 128'(out_valid), 128'(exp_ov));
            checkOutput("busy", 128'(busy), 128'(m_busy));
            checkOutput("in_ready", 128'(in_ready), 128'(exp_ir));
            if (!exp_ov) checkOutput("out_zero_when_invalid", out_blk, 128'd0);
            if (prev_hold) checkOutput("out_stable_stall", out_blk, prev_out);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output: actual=%h required=no output", out_blk);
                end else begin
                    checkOutput("plaintext", out_blk, exp_q.pop_front());
                end
            end
            prev_hold = (out_valid === 1'b1) && !out_ready && rst && !abort_sig;
            prev_out  = out_blk;
            if (!rst || abort_sig) begin
                m_busy = 1'b0;
            end else if (exp_ov && out_ready) begin
                m_busy = 1'b0;
            end else if (!m_busy && in_valid) begin
                m_busy = 1'b1;
                m_acc  = cyc + 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=time limit reached required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [255:0] k;
        logic [127:0] p;
        int waited;
        buildSbox();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out", out_blk, 128'd0);
        checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset_busy", 128'(busy), 128'd0);
        checkOutput("reset_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        $display("[TB] reset released");

        // Known-answer vectors; the second is offered while the first is busy
        applyStimulus(C3_KEY, C3_CT, C3_PT);
        applyStimulus('0, Z_CT, 128'd0);

        // Block held during ROUND with a different key must wait for IDLE
        ready_force_en = 1'b0;
        applyStimulus(C3_KEY, C3_CT, C3_PT);
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        p = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(k, encrypt(k, p), p);
        waitDrain();

        // Backpressure: stall DONE for 20 cycles with a new block waiting
        ready_force_en = 1'b1;
        ready_force    = 1'b0;
        applyStimulus(C3_KEY, C3_CT, C3_PT);
        in_valid = 1'b1;
        key_in   = '0;
        in_blk   = Z_CT;
        waited   = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (out_valid !== 1'b1 && waited < 40);
        repeat (20) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 128'(in_ready), 128'd0);
        end
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        @(negedge clk);
        checkOutput("done_cycle_no_accept", 128'(in_ready), 128'd0);
        @(negedge clk);
        checkOutput("idle_accept_ready", 128'(in_ready), 128'd1);
        exp_q.push_back(128'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitDrain();

        // Reset in the middle of a block, at cnt=7
        applyStimulus(C3_KEY, C3_CT, C3_PT);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_out_valid", 128'(out_valid), 128'd0);
        checkOutput("midreset_out", out_blk, 128'd0);
        checkOutput("midreset_busy", 128'(busy), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(C3_KEY, C3_CT, C3_PT);
        waitDrain();

`ifdef AES_DECR_ABORT_EN
        // Abort at cnt=3, then abort alongside an offered block in IDLE
        applyStimulus(C3_KEY, C3_CT, C3_PT);
        repeat (11) @(posedge clk);
        #1;
        abort_sig = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        abort_sig = 1'b0;
        @(negedge clk);
        checkOutput("abort_out_valid", 128'(out_valid), 128'd0);
        checkOutput("abort_busy", 128'(busy), 128'd0);
        @(posedge clk);
        #1;
        abort_sig = 1'b1;
        in_valid  = 1'b1;
        key_in    = C3_KEY;
        in_blk    = C3_CT;
        @(negedge clk);
        checkOutput("abort_blocks_ready", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1;
        abort_sig = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        checkOutput("abort_no_accept", 128'(busy), 128'd0);
        waitDrain();
`endif

        // Randomized loopback against the forward model
        ready_force_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(k, encrypt(k, p), p);
        end
        ready_force_en = 1'b1;
        ready_force    = 1'b1;
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
